pattern_generator: RTL and testbench

//   Output-side counterpart of the acquisition path: converts a stream of 16-bit per-channel

---
 rtl/pattern_generator_pkg.sv | 7 +
 rtl/pattern_generator_p2s.sv | 32 +++
 rtl/pattern_generator.sv | 104 ++++++++++
 tb/tb_pattern_generator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_generator_pkg.sv
// pattern_generator_pkg: shared defaults and FSM state encoding for the pattern generator
package pattern_generator_pkg;
  localparam int PG_NUM_CH = 16;
  localparam int PG_WORD_W = 16;
  localparam int PG_DIV_W = 8;
  typedef enum logic [1:0] {IDLE, PRIME, RUN, STALL} state_t;
endpackage

// File: rtl/pattern_generator_p2s.sv
// parallel_to_serial: one channel's hold word, shift register and registered pin bit
module parallel_to_serial
  import pattern_generator_pkg::*;
#(
  parameter int WORD_W = PG_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic              load,
  input  logic              transfer,
  input  logic              shift,
  input  logic              keep,
  input  logic [WORD_W-1:0] data,
  output logic              full,
  output logic              bit_out
);
  logic [WORD_W-1:0] hold, sh;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hold <= '0;
      sh <= '0;
      full <= 1'b0;
      bit_out <= 1'b0;
    end else begin
      if (load) hold <= data;
      full <= clear ? 1'b0 : load ? 1'b1 : transfer && !keep ? 1'b0 : full;
      sh <= transfer ? hold >> 1 : shift ? sh >> 1 : sh;
      bit_out <= !en ? 1'b0 : transfer ? hold[0] : shift ? sh[0] : bit_out;
    end
endmodule

// File: rtl/pattern_generator.sv
// pattern_generator: streams round-robin channel words out as LSB-first pin patterns at the divided tick rate
// Optional `PATTERN_LOOP_EN adds loop_mode: each channel replays its first word forever.
module pattern_generator
  import pattern_generator_pkg::*;
#(
  parameter int NUM_CH = PG_NUM_CH,
  parameter int WORD_W = PG_WORD_W,
  parameter int DIV_W = PG_DIV_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              gen_enable,
  input  logic [DIV_W-1:0]  clock_divisor,
  input  logic [NUM_CH-1:0] channel_enable,
`ifdef PATTERN_LOOP_EN
  input  logic              loop_mode,
`endif
  output logic [NUM_CH-1:0] probe_out,
  output logic [NUM_CH-1:0] probe_oe,
  output logic              active,
  output logic              underrun
);
  localparam int PTR_W = $clog2(NUM_CH);
  localparam int BIT_W = $clog2(WORD_W);
  state_t state, state_nxt;
  logic gen_q, gen_rise, tick, boundary, starve, cfg_loop, loop_in, accept;
  logic [DIV_W-1:0] cfg_div, cnt;
  logic [NUM_CH-1:0] cfg_en, full, en_nxt;
  logic [PTR_W-1:0] ptr, nxt_ptr, first_ptr, cand;
  logic [BIT_W-1:0] bitcnt;
`ifdef PATTERN_LOOP_EN
  assign loop_in = loop_mode;
`else
  assign loop_in = 1'b0;
`endif
  assign gen_rise = gen_enable & ~gen_q;
  assign tick = state == RUN && cnt == cfg_div;
  assign boundary = tick && bitcnt == '0;
  assign starve = boundary && (full & cfg_en) != cfg_en;
  assign in_ready = (state == PRIME || state == RUN) && !full[ptr];
  assign accept = in_valid && in_ready;
  assign active = state == RUN;
  assign en_nxt = gen_rise ? channel_enable : cfg_en;
  always_comb begin
    state_nxt = !gen_enable ? IDLE
              : state == IDLE ? (gen_rise && channel_enable != '0 ? PRIME : IDLE)
              : state == PRIME ? ((full & cfg_en) == cfg_en ? RUN : PRIME)
              : state == RUN && starve ? STALL : state;
    nxt_ptr = ptr;
    cand = ptr;
    for (int k = NUM_CH - 1; k >= 1; k--) begin
      cand = ptr + PTR_W'(k);
      if (cfg_en[cand]) nxt_ptr = cand;
    end
    first_ptr = PTR_W'(NUM_CH - 1);
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (channel_enable[k]) first_ptr = PTR_W'(k);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      gen_q <= 1'b0;
      cfg_div <= '0;
      cfg_en <= '0;
      cfg_loop <= 1'b0;
      ptr <= '0;
      cnt <= '0;
      bitcnt <= '0;
      underrun <= 1'b0;
      probe_oe <= '0;
    end else begin
      state <= state_nxt;
      gen_q <= gen_enable;
      if (gen_rise) begin
        cfg_div <= clock_divisor;
        cfg_en <= channel_enable;
        cfg_loop <= loop_in;
      end
      ptr <= gen_rise ? first_ptr : accept ? nxt_ptr : ptr;
      cnt <= state != RUN || tick ? '0 : cnt + 1'b1;
      bitcnt <= state != RUN ? '0 : !tick ? bitcnt : bitcnt == BIT_W'(WORD_W - 1) ? '0 : bitcnt + 1'b1;
      underrun <= gen_rise ? 1'b0 : underrun | starve;
      probe_oe <= state_nxt != IDLE ? en_nxt : '0;
    end
  // a word boundary that finds any hold empty stalls everything, so no channel transfers
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    parallel_to_serial #(.WORD_W(WORD_W)) u_p2s (
      .clk(clk),
      .rst(rst),
      .en(cfg_en[i]),
      .clear(state == IDLE),
      .load(accept && ptr == PTR_W'(i)),
      .transfer(boundary && !starve && cfg_en[i]),
      .shift(tick && bitcnt != '0 && cfg_en[i]),
      .keep(cfg_loop),
      .data(in_data),
      .full(full[i]),
      .bit_out(probe_out[i])
    );
  end
endmodule

// File: tb/tb_pattern_generator.sv
// tb_pattern_generator: randomized scoreboard bench; expected pin vectors derived from word order and LSB-first bit rule
module tb_pattern_generator;
  logic clk = 0, rst = 0, in_valid = 0, gen_enable = 0;
  logic [15:0] in_data = 0, channel_enable = 0;
  logic [7:0] clock_divisor = 0;
  logic in_ready, active, underrun;
  logic [15:0] probe_out, probe_oe;
`ifdef PATTERN_LOOP_EN
  logic loop_mode = 0;
`endif
  int vec = 0, miss = 0;
  logic [15:0] exp_q[$];
  logic [15:0] words[$];
  logic [15:0] cur_en = 0, last = 0, e;
  int cur_div = 0, c = 0;
  bit cur_loop = 0, mon_on = 0, mon_done = 0, have_last = 0, act_q = 0;

  always #5 clk = ~clk;

  pattern_generator dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .gen_enable(gen_enable),
    .clock_divisor(clock_divisor),
    .channel_enable(channel_enable),
`ifdef PATTERN_LOOP_EN
    .loop_mode(loop_mode),
`endif
    .probe_out(probe_out),
    .probe_oe(probe_oe),
    .active(active),
    .underrun(underrun)
  );

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    vec++;
    if (a !== x) begin
      miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, x, $time);
    end
  endtask

  // monitor: from the rise of active, every cur_div+1 cycles the pins must show the next expected vector
  always @(negedge clk) begin
    if (!rst) mon_on = 0;
    else if (!mon_on) begin
      if (active && !act_q) begin
        mon_on = 1;
        c = 0;
        have_last = 0;
      end
    end else begin
      c++;
      if (c % (cur_div + 1) == 0) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("probe", 32'(probe_out), 32'(e));
          chk("oe", 32'(probe_oe), 32'(cur_en));
          chk("no_underrun", 32'(underrun), 0);
          last = e;
          have_last = 1;
        end else begin
          if (cur_loop) chk("loop_underrun", 32'(underrun), 0);
          else begin
            chk("underrun", 32'(underrun), 1);
            chk("freeze", 32'(probe_out), 32'(last));
            chk("stall_ready", 32'(in_ready), 0);
            chk("stall_active", 32'(active), 0);
          end
          mon_on = 0;
          mon_done = 1;
        end
      end else if (have_last) chk("hold", 32'(probe_out), 32'(last));
    end
    act_q = active;
  end

  task automatic setup(input logic [15:0] en, input logic [7:0] div, input int nw, input bit lp);
    int ch[$];
    logic [15:0] v;
    for (int i = 0; i < 16; i++) if (en[i]) ch.push_back(i);
    if (words.size() == 0) repeat ((lp ? 1 : nw) * ch.size()) words.push_back(16'($urandom));
    exp_q.delete();
    for (int g = 0; g < nw; g++)
      for (int b = 0; b < 16; b++) begin
        v = '0;
        foreach (ch[k]) v[ch[k]] = words[(lp ? 0 : g) * ch.size() + k][b];
        exp_q.push_back(v);
      end
    cur_en = en;
    cur_div = int'(div);
    cur_loop = lp;
    mon_done = 0;
    @(negedge clk);
    gen_enable = 0;
    channel_enable = en;
    clock_divisor = div;
`ifdef PATTERN_LOOP_EN
    loop_mode = lp;
`endif
    @(negedge clk);
    gen_enable = 1;
    @(negedge clk);
    chk("prime_ready", 32'(in_ready), 1);
    chk("prime_oe", 32'(probe_oe), 32'(en));
    chk("prime_underrun", 32'(underrun), 0);
    channel_enable = 16'($urandom);
    clock_divisor = 8'($urandom);
  endtask

  task automatic feed(input bit gaps);
    int t;
    foreach (words[j]) begin
      if (gaps && $urandom_range(3) == 0) begin
        in_valid = 0;
        @(negedge clk);
      end
      in_valid = 1;
      in_data = words[j];
      t = 0;
      while (!in_ready && t < 2000) begin
        @(negedge clk);
        t++;
      end
      chk("accept", 32'(in_ready), 1);
      @(negedge clk);
    end
    in_valid = 0;
    in_data = 16'($urandom);
  endtask

  task automatic run_test(input logic [15:0] en, input logic [7:0] div, input int nw, input bit lp, input bit gaps);
    int t;
    setup(en, div, nw, lp);
    feed(gaps);
    words.delete();
    t = 0;
    while (!mon_done && t < 8000) begin
      @(negedge clk);
      t++;
    end
    chk("done", 32'(mon_done), 1);
    if (lp) begin
      chk("loop_ready", 32'(in_ready), 0);
      chk("loop_active", 32'(active), 1);
    end else begin
      repeat (3) @(negedge clk);
      chk("frozen", 32'(probe_out), 32'(last));
      chk("stall_ready2", 32'(in_ready), 0);
      chk("stall_sticky", 32'(underrun), 1);
      chk("stall_oe", 32'(probe_oe), 32'(en));
      channel_enable = en;
      gen_enable = 0;
      @(negedge clk);
      chk("idle_oe", 32'(probe_oe), 0);
      gen_enable = 1;
      @(negedge clk);
      chk("rearm_underrun", 32'(underrun), 0);
      chk("rearm_ready", 32'(in_ready), 1);
      chk("rearm_active", 32'(active), 0);
    end
    gen_enable = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [15:0] en;
    int t;
    repeat (2) @(negedge clk);
    chk("rst_probe", 32'(probe_out), 0);
    chk("rst_oe", 32'(probe_oe), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_underrun", 32'(underrun), 0);
    rst = 1;
    @(negedge clk);
    words = '{16'hA5A5, 16'h0F0F};
    run_test(16'h0001, 8'd0, 2, 0, 0);
    run_test(16'h8005, 8'd0, 2, 0, 1);
    run_test(16'h0001, 8'd3, 2, 0, 0);
    channel_enable = 16'h0000;
    gen_enable = 1;
    repeat (4) begin
      @(negedge clk);
      chk("zero_active", 32'(active), 0);
      chk("zero_ready", 32'(in_ready), 0);
      chk("zero_oe", 32'(probe_oe), 0);
    end
    gen_enable = 0;
    @(negedge clk);
    repeat (6) begin
      en = 16'($urandom);
      if (en == 0) en = 16'h0001;
      run_test(en, 8'($countones(en) > 12 ? $urandom_range(3, 1) : $urandom_range(3, 0)),
               int'($urandom_range(3, 1)), 0, $countones(en) <= 4);
    end
    setup(16'h0003, 8'd1, 2, 0);
    feed(0);
    words.delete();
    t = 0;
    while (!active && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("reset_run_active", 32'(active), 1);
    repeat (5) @(negedge clk);
    #3 rst = 0;
    #1;
    chk("arst_probe", 32'(probe_out), 0);
    chk("arst_oe", 32'(probe_oe), 0);
    chk("arst_ready", 32'(in_ready), 0);
    chk("arst_active", 32'(active), 0);
    chk("arst_underrun", 32'(underrun), 0);
    gen_enable = 0;
    @(negedge clk);
    #2 rst = 1;
    exp_q.delete();
    repeat (2) @(negedge clk);
`ifdef PATTERN_LOOP_EN
    words = '{16'h00FF};
    run_test(16'h0001, 8'd0, 4, 1, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
